// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch stage. Holds the program counter, runs a
//            req/ack handshake with instruction memory and presents PC and
//            instruction to the IF_ID register. Handles branch redirects,
//            stalls, and one entry of buffering for data returned while stalled.
// Ports    : clk, rst (sync, active-low)
//            stall              - hold; IF_ID outputs frozen
//            brFlag, brTarget   - one-cycle redirect from ID
//            imemReq/Addr       - request to instruction memory
//            imemAck/Data       - completion and fetched word (same cycle)
//            ifPC/ifInst/ifValid- registered outputs to IF_ID
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              brFlag,
    input  logic [ADDR_W-1:0] brTarget,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [INST_W-1:0] imemData,
    output logic [ADDR_W-1:0] ifPC,
    output logic [INST_W-1:0] ifInst,
    output logic              ifValid
);

    localparam logic [0:0] c_ST_FETCH = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    logic [0:0]        r_state,    w_state;
    logic [ADDR_W-1:0] r_pc,       w_pc;
    logic              r_squash,   w_squash;
    logic [ADDR_W-1:0] r_sq_addr,  w_sq_addr;
    logic [ADDR_W-1:0] r_buf_pc,   w_buf_pc;
    logic [INST_W-1:0] r_buf_inst, w_buf_inst;
    logic [ADDR_W-1:0] r_if_pc,    w_if_pc;
    logic [INST_W-1:0] r_if_inst,  w_if_inst;
    logic              r_if_valid, w_if_valid;

    // Low address bits of the redirect target are discarded by design.
    logic w_unused_br_lsb;
    assign w_unused_br_lsb = ^brTarget[1:0];

    // While a squashed transaction is still in flight the old address must be
    // held on the bus even though pc already points at the redirect target.
    assign imemReq  = rst && (r_state == c_ST_FETCH);
    assign imemAddr = r_squash ? r_sq_addr : r_pc;

    assign ifPC    = r_if_pc;
    assign ifInst  = r_if_inst;
    assign ifValid = r_if_valid;

    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_squash   = r_squash;
        w_sq_addr  = r_sq_addr;
        w_buf_pc   = r_buf_pc;
        w_buf_inst = r_buf_inst;
        w_if_pc    = r_if_pc;
        w_if_inst  = r_if_inst;
        w_if_valid = r_if_valid;

        if (brFlag) begin
            w_pc       = {brTarget[ADDR_W-1:2], 2'b00};
            w_state    = c_ST_FETCH;
            w_buf_pc   = '0;
            w_buf_inst = '0;
            w_if_pc    = '0;
            w_if_inst  = '0;
            w_if_valid = 1'b0;
            if ((r_state == c_ST_FETCH) && !imemAck) begin
                // Request still open: let it finish, then drop its data.
                w_squash = 1'b1;
                if (!r_squash) begin
                    w_sq_addr = r_pc;
                end
            end else begin
                w_squash = 1'b0;
            end
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (imemAck) begin
                        if (r_squash) begin
                            w_squash = 1'b0;
                        end else if (!stall) begin
                            w_if_pc    = r_pc;
                            w_if_inst  = imemData;
                            w_if_valid = 1'b1;
                            w_pc       = r_pc + c_PC_STEP;
                        end else begin
                            w_buf_pc   = r_pc;
                            w_buf_inst = imemData;
                            w_pc       = r_pc + c_PC_STEP;
                            w_state    = c_ST_FULL;
                        end
                    end else if (!stall) begin
                        // Nothing new arrived: present a bubble.
                        w_if_valid = 1'b0;
                    end
                end
                default: begin
                    if (!stall) begin
                        w_if_pc    = r_buf_pc;
                        w_if_inst  = r_buf_inst;
                        w_if_valid = 1'b1;
                        w_state    = c_ST_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_FETCH;
            r_pc       <= RESET_PC;
            r_squash   <= 1'b0;
            r_sq_addr  <= '0;
            r_buf_pc   <= '0;
            r_buf_inst <= '0;
            r_if_pc    <= '0;
            r_if_inst  <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_squash   <= w_squash;
            r_sq_addr  <= w_sq_addr;
            r_buf_pc   <= w_buf_pc;
            r_buf_inst <= w_buf_inst;
            r_if_pc    <= w_if_pc;
            r_if_inst  <= w_if_inst;
            r_if_valid <= w_if_valid;
        end
    end

endmodule
`default_nettype wire
